// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter peripheral.
//
// Contents:
//   REG_*            register select values seen on the bus addr field
//   CTRL_*_BIT       bit positions inside a CTRL write
//   ST_*_BIT         bit positions inside the status read-back word
//   tx_state_t       transmitter shifter state encoding
package uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_DIV    = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int CTRL_CLR_OVF_BIT = 0;
   localparam int CTRL_FLUSH_BIT   = 1;

   localparam int ST_COUNT_W      = 8;
   localparam int ST_EMPTY_BIT    = 8;
   localparam int ST_FULL_BIT     = 9;
   localparam int ST_BUSY_BIT     = 10;
   localparam int ST_OVERFLOW_BIT = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_tx_io_sync_byte_fifo.sv
// sync_byte_fifo -- single-clock byte FIFO with show-ahead output.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   flush        discard all contents (pointers and count return to zero)
//   push, din    write a byte; accepted when not full, or when full with a
//                pop in the same cycle
//   pop, dout    dout always shows the oldest entry; pop removes it
//   count        number of stored entries, 0..FIFO_DEPTH
//   full, empty  count == FIFO_DEPTH / count == 0
//
// dout is read combinationally so a consumer can take the head byte in the
// same cycle it pops it.
module sync_byte_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        push,
   input  logic [7:0]                  din,
   input  logic                        pop,
   output logic [7:0]                  dout,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_reg == CW'(FIFO_DEPTH));
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign push_ok = push && (!full || pop_ok);

   assign dout  = mem[rd_ptr_reg];
   assign count = count_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   // Power-of-two depth: pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_io.sv
// uart_tx_io -- memory-mapped 8N1 UART transmitter slave.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   we         write strobe for this slave
//   addr       0 = TXDATA (push byte), 1 = DIV, 2 = CTRL, 3 = ignored
//   wdata      bus write data
//   rdata      combinational read-back: divisor at addr 1, status elsewhere
//   tx         registered serial line, idle high
//   busy       frame in progress or bytes queued (registered)
//
// The shifter drives an internal line level; tx is that level delayed by
// one register, so a byte written to an idle block at edge k is popped at
// k+1 and the start bit appears on tx from k+2.
module uart_tx_io
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int DIV_DEFAULT = 868,
   parameter int DIV_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [1:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        tx,
   output logic        busy
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   tx_state_t        state_reg;
   tx_state_t        state_next;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_wr;
   logic [DIV_W-1:0] frame_div_reg;
   logic [DIV_W-1:0] frame_div_next;
   logic [DIV_W-1:0] cnt_reg;
   logic [DIV_W-1:0] cnt_next;
   logic [7:0]       shift_reg;
   logic [7:0]       shift_next;
   logic [2:0]       bit_idx_reg;
   logic [2:0]       bit_idx_next;
   logic             line_reg;
   logic             line_next;
   logic             tx_reg;
   logic             busy_reg;
   logic             overflow_reg;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_flush;
   logic             fifo_full;
   logic             fifo_empty;
   logic [7:0]       fifo_dout;
   logic [CW-1:0]    fifo_count;

   logic             bit_done;
   logic             frame_load;
   logic             push_drop;
   logic             ovf_clear;
   logic [31:0]      status;
   logic             unused_wdata;

   // ---------------------------------------------------------------
   // Register decode
   // ---------------------------------------------------------------
   assign fifo_push  = we && (addr == REG_TXDATA);
   assign fifo_flush = we && (addr == REG_CTRL) && wdata[CTRL_FLUSH_BIT];
   assign ovf_clear  = we && (addr == REG_CTRL) && wdata[CTRL_CLR_OVF_BIT];
   assign push_drop  = fifo_push && fifo_full && !fifo_pop;
   assign div_wr     = wdata[DIV_W-1:0];

   // Only a subset of the bus word is decoded.
   assign unused_wdata = ^wdata;

   sync_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .din   (wdata[7:0]),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bit_done = (cnt_reg == '0);

   // ---------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         div_reg       <= DIV_W'(DIV_DEFAULT);
         frame_div_reg <= DIV_W'(DIV_DEFAULT);
         cnt_reg       <= '0;
         shift_reg     <= '0;
         bit_idx_reg   <= '0;
         line_reg      <= 1'b1;
         tx_reg        <= 1'b1;
         busy_reg      <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         frame_div_reg <= frame_div_next;
         cnt_reg       <= cnt_next;
         shift_reg     <= shift_next;
         bit_idx_reg   <= bit_idx_next;
         line_reg      <= line_next;
         tx_reg        <= line_reg;
         busy_reg      <= (state_reg != IDLE) || !fifo_empty;
         if (we && (addr == REG_DIV)) begin
            // A zero divisor would stall the baud counter; clamp to 1.
            div_reg <= (div_wr == '0) ? DIV_W'(1) : div_wr;
         end
         if (ovf_clear) begin
            overflow_reg <= 1'b0;
         end else if (push_drop) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:  if (!fifo_empty) state_next = START;
         START: if (bit_done) state_next = DATA;
         DATA:  if (bit_done && (bit_idx_reg == 3'd7)) state_next = STOP;
         STOP:  if (bit_done) state_next = fifo_empty ? IDLE : START;
      endcase
   end

   // ---------------------------------------------------------------
   // Output / datapath logic
   // ---------------------------------------------------------------
   always_comb begin
      fifo_pop       = 1'b0;
      frame_load     = 1'b0;
      frame_div_next = frame_div_reg;
      cnt_next       = cnt_reg;
      shift_next     = shift_reg;
      bit_idx_next   = bit_idx_reg;
      line_next      = line_reg;

      unique case (state_reg)
         IDLE: begin
            frame_load = !fifo_empty;
         end
         START: begin
            if (bit_done) begin
               cnt_next     = frame_div_reg - DIV_W'(1);
               bit_idx_next = 3'd0;
               line_next    = shift_reg[0];
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_next = frame_div_reg - DIV_W'(1);
               if (bit_idx_reg == 3'd7) begin
                  line_next = 1'b1;
               end else begin
                  // Shift right so the next data bit sits in bit 0.
                  bit_idx_next = bit_idx_reg + 3'd1;
                  shift_next   = {1'b0, shift_reg[7:1]};
                  line_next    = shift_reg[1];
               end
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               // Chain straight into the next start bit when data is queued.
               frame_load = !fifo_empty;
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
      endcase

      // Frame start: take the head byte and latch the divisor for the
      // whole frame so later DIV writes only affect following frames.
      if (frame_load) begin
         fifo_pop       = 1'b1;
         shift_next     = fifo_dout;
         frame_div_next = div_reg;
         cnt_next       = div_reg - DIV_W'(1);
         line_next      = 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Read-back
   // ---------------------------------------------------------------
   always_comb begin
      status                        = '0;
      status[ST_COUNT_W-1:0]        = ST_COUNT_W'(fifo_count);
      status[ST_EMPTY_BIT]          = fifo_empty;
      status[ST_FULL_BIT]           = fifo_full;
      status[ST_BUSY_BIT]           = busy_reg;
      status[ST_OVERFLOW_BIT]       = overflow_reg;
   end

   assign rdata = (addr == REG_DIV) ? 32'(div_reg) : status;
   assign tx    = tx_reg;
   assign busy  = busy_reg;

endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io -- self-checking bench for uart_tx_io.
//
// The reference model describes the line as a timeline of frames: each
// frame has a start edge, a latched divisor and a byte, and the line level
// at any edge follows from (edge - start) / divisor. Bytes wait in a queue.
module tb_uart_tx_io;

   localparam int DEPTH = 8;
   localparam int DIVD  = 868;
   localparam int DW    = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        tx;
   logic        busy;

   always #5 clk = ~clk;

   uart_tx_io #(
      .FIFO_DEPTH  (DEPTH),
      .DIV_DEFAULT (DIVD),
      .DIV_W       (DW)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .tx    (tx),
      .busy  (busy)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- reference model ----------------
   logic [7:0] q[$];
   int         m_div;
   logic       m_ovf;
   logic       m_active;
   int         m_cyc = 0;
   int         m_p;
   int         m_fdiv;
   logic [7:0] m_fbyte;
   logic       m_line;
   logic       m_tx;
   logic       m_busy;

   function automatic logic frame_bit(input logic [7:0] b, input int i, input int d);
      int k;
      k = i / d;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return 1'b1;
   endfunction

   function automatic logic model_line();
      if (!m_active) return 1'b1;
      return frame_bit(m_fbyte, m_cyc - m_p, m_fdiv);
   endfunction

   function automatic logic [31:0] model_rdata(input logic [1:0] a);
      logic [31:0] s;
      if (a == 2'd1) return 32'(m_div);
      s = '0;
      s[7:0] = 8'(q.size());
      s[8]   = (q.size() == 0);
      s[9]   = (q.size() == DEPTH);
      s[10]  = m_busy;
      s[11]  = m_ovf;
      return s;
   endfunction

   task automatic model_reset();
      q.delete();
      m_div    = DIVD;
      m_ovf    = 1'b0;
      m_active = 1'b0;
      m_line   = 1'b1;
      m_tx     = 1'b1;
      m_busy   = 1'b0;
   endtask

   task automatic model_edge(input logic r, input logic w, input logic [1:0] a,
                             input logic [31:0] d);
      logic tx_new;
      logic busy_new;
      m_cyc++;
      if (r) begin
         model_reset();
         return;
      end
      tx_new   = m_line;
      busy_new = m_active || (q.size() != 0);
      if (m_active && (m_cyc == m_p + 10 * m_fdiv)) m_active = 1'b0;
      if (!m_active && (q.size() != 0)) begin
         m_fbyte  = q.pop_front();
         m_fdiv   = m_div;
         m_p      = m_cyc;
         m_active = 1'b1;
      end
      if (w) begin
         case (a)
            2'd0: if (q.size() < DEPTH) q.push_back(d[7:0]); else m_ovf = 1'b1;
            2'd1: m_div = (d[DW-1:0] == 0) ? 1 : int'(d[DW-1:0]);
            2'd2: begin
               if (d[0]) m_ovf = 1'b0;
               if (d[1]) q.delete();
            end
            default: ;
         endcase
      end
      m_line = model_line();
      m_tx   = tx_new;
      m_busy = busy_new;
   endtask

   // One clock: drive at the negedge, let the edge happen, return at the
   // next negedge with inputs idle (addr left as driven for read-back).
   task automatic cycle(input logic r, input logic w, input logic [1:0] a,
                        input logic [31:0] d);
      rst = r; we = w; addr = a; wdata = d;
      @(posedge clk);
      model_edge(r, w, a, d);
      @(negedge clk);
      rst = 1'b0; we = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      model_reset();
      repeat (3) cycle(1'b1, 1'b0, 2'd0, 32'h0);
      cycle(1'b0, 1'b0, 2'd0, 32'h0);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (rdata !== 32'h0000_0100) begin errors++; $display("FAIL reset_status got %h exp 00000100", rdata); end
      cycle(1'b0, 1'b0, 2'd1, 32'h0);
      checks++; if (rdata !== 32'd868) begin errors++; $display("FAIL reset_div got %0d exp 868", rdata); end
   endtask

   task automatic test_single_frame();
      int          n_fall;
      logic [7:0]  b;
      logic        exp_lvl;
      b = 8'hA5;
      cycle(1'b0, 1'b1, 2'd1, 32'd4);
      cycle(1'b0, 1'b1, 2'd0, {24'h0, b});
      n_fall = -1;
      for (int n = 1; n <= 10; n++) begin
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
         checks++; if (tx !== m_tx) begin errors++; $display("FAIL single_tx cyc=%0d got %b exp %b", m_cyc, tx, m_tx); end
         if (tx === 1'b0) begin n_fall = n; break; end
      end
      checks++; if (n_fall != 2) begin errors++; $display("FAIL single_fall_latency got %0d exp 2", n_fall); end
      for (int i = 0; i < 40; i++) begin
         if (i > 0) cycle(1'b0, 1'b0, 2'd0, 32'h0);
         exp_lvl = frame_bit(b, i, 4);
         checks++; if (tx !== exp_lvl) begin errors++; $display("FAIL single_wave i=%0d got %b exp %b", i, tx, exp_lvl); end
         checks++; if (tx !== m_tx) begin errors++; $display("FAIL single_model_tx cyc=%0d got %b exp %b", m_cyc, tx, m_tx); end
         checks++; if (rdata !== model_rdata(addr)) begin errors++; $display("FAIL single_rdata cyc=%0d got %h exp %h", m_cyc, rdata, model_rdata(addr)); end
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_last_stop got %b exp 1", busy); end
      cycle(1'b0, 1'b0, 2'd0, 32'h0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after_stop got %b exp 0", busy); end
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx got %b exp 1", tx); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0;
      logic [7:0] b1;
      logic       exp_lvl;
      int         n_fall;
      b0 = 8'h55;
      b1 = 8'h0F;
      cycle(1'b0, 1'b1, 2'd1, 32'd2);
      cycle(1'b0, 1'b1, 2'd0, {24'h0, b0});
      checks++; if (rdata[7:0] !== 8'd1) begin errors++; $display("FAIL b2b_count_first got %0d exp 1", rdata[7:0]); end
      cycle(1'b0, 1'b1, 2'd0, {24'h0, b1});
      checks++; if (rdata[7:0] !== 8'd1) begin errors++; $display("FAIL b2b_count_second got %0d exp 1", rdata[7:0]); end
      n_fall = -1;
      for (int n = 1; n <= 10; n++) begin
         if (tx === 1'b0) begin n_fall = n; break; end
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
      end
      checks++; if (n_fall < 0) begin errors++; $display("FAIL b2b_no_start got %b exp 0", tx); end
      for (int i = 0; i < 42; i++) begin
         if (i > 0) cycle(1'b0, 1'b0, 2'd0, 32'h0);
         exp_lvl = (i < 20) ? frame_bit(b0, i, 2) : (i < 40) ? frame_bit(b1, i - 20, 2) : 1'b1;
         checks++; if (tx !== exp_lvl) begin errors++; $display("FAIL b2b_wave i=%0d got %b exp %b", i, tx, exp_lvl); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL b2b_busy cyc=%0d got %b exp %b", m_cyc, busy, m_busy); end
         checks++; if (rdata !== model_rdata(addr)) begin errors++; $display("FAIL b2b_rdata cyc=%0d got %h exp %h", m_cyc, rdata, model_rdata(addr)); end
      end
   endtask

   task automatic test_overflow_flush();
      cycle(1'b0, 1'b1, 2'd1, 32'd100);
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 2'd0, $urandom());
      checks++; if (rdata !== 32'h0000_0E08) begin errors++; $display("FAIL ovf_status got %h exp 00000e08", rdata); end
      cycle(1'b0, 1'b1, 2'd2, 32'h1);
      checks++; if (rdata !== 32'h0000_0608) begin errors++; $display("FAIL ovf_clear got %h exp 00000608", rdata); end
      cycle(1'b0, 1'b1, 2'd2, 32'h2);
      checks++; if (rdata !== 32'h0000_0500) begin errors++; $display("FAIL flush_status got %h exp 00000500", rdata); end
      for (int n = 0; n < 1200 && (m_active || q.size() != 0 || m_busy); n++) begin
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
         checks++; if (tx !== m_tx) begin errors++; $display("FAIL flush_tx cyc=%0d got %b exp %b", m_cyc, tx, m_tx); end
         checks++; if (rdata !== model_rdata(addr)) begin errors++; $display("FAIL flush_rdata cyc=%0d got %h exp %h", m_cyc, rdata, model_rdata(addr)); end
      end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_end_busy got %b exp 0", busy); end
   endtask

   task automatic test_div_change();
      int k;
      int fall;
      cycle(1'b0, 1'b1, 2'd1, 32'd5);
      cycle(1'b0, 1'b1, 2'd0, 32'h3C);
      k = m_cyc;
      cycle(1'b0, 1'b1, 2'd0, 32'hC9);
      repeat (3) cycle(1'b0, 1'b0, 2'd0, 32'h0);
      cycle(1'b0, 1'b1, 2'd1, 32'd3);
      fall = -1;
      for (int n = 0; n < 200; n++) begin
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
         checks++; if (tx !== m_tx) begin errors++; $display("FAIL divchg_tx cyc=%0d got %b exp %b", m_cyc, tx, m_tx); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL divchg_busy cyc=%0d got %b exp %b", m_cyc, busy, m_busy); end
         if (busy === 1'b0) begin fall = m_cyc; break; end
      end
      checks++; if (fall - k != 82) begin errors++; $display("FAIL divchg_span got %0d exp 82", fall - k); end
      cycle(1'b0, 1'b1, 2'd1, 32'd0);
      cycle(1'b0, 1'b0, 2'd1, 32'd0);
      checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL div_zero got %0d exp 1", rdata); end
   endtask

   task automatic test_reset_midframe();
      cycle(1'b0, 1'b1, 2'd1, 32'd4);
      cycle(1'b0, 1'b1, 2'd0, 32'h00);
      cycle(1'b0, 1'b1, 2'd0, 32'hFF);
      for (int n = 0; n < 100 && !(m_active && (m_cyc - m_p == 17)); n++)
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
      checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx got %b exp 0", tx); end
      cycle(1'b1, 1'b0, 2'd0, 32'h0);
      checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b exp 1", tx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      checks++; if (rdata !== 32'h0000_0100) begin errors++; $display("FAIL midrst_status got %h exp 00000100", rdata); end
      for (int n = 0; n < 20; n++) begin
         cycle(1'b0, 1'b0, 2'd0, 32'h0);
         checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midrst_quiet cyc=%0d got %b exp 1", m_cyc, tx); end
      end
   endtask

   task automatic test_random();
      int          r;
      logic        w;
      logic [1:0]  a;
      logic [31:0] d;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 199));
         d = $urandom();
         w = 1'b1;
         if (r < 16)       a = 2'd0;
         else if (r < 19) begin a = 2'd1; d = 32'($urandom_range(0, 4)); end
         else if (r < 22) begin a = 2'd2; d = 32'h1; end
         else if (r == 22) begin a = 2'd2; d = 32'h2; end
         else if (r == 23) a = 2'd3;
         else begin w = 1'b0; a = 2'($urandom_range(0, 3)); end
         cycle(1'b0, w, a, d);
         checks++; if (tx !== m_tx) begin errors++; $display("FAIL rand_tx cyc=%0d got %b exp %b", m_cyc, tx, m_tx); end
         checks++; if (busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got %b exp %b", m_cyc, busy, m_busy); end
         checks++; if (rdata !== model_rdata(addr)) begin errors++; $display("FAIL rand_rdata cyc=%0d addr=%0d got %h exp %h", m_cyc, addr, rdata, model_rdata(addr)); end
      end
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; addr = 2'd0; wdata = 32'h0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow_flush();
      test_div_change();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at cyc=%0d", m_cyc);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/uart_tx_io.md
Name: uart_tx_io

Overview:
- Memory-mapped UART transmitter peripheral. Hangs off the CPU I/O bus decoder as one more write-enabled slave, next to the counter and LED slaves.
- Takes bus write data and a register select, buffers bytes in a small FIFO, and serialises them as 8N1 frames on a single TX pin.
- Returns a status/divisor word for the CPU read-back mux.

Parameters:
- FIFO_DEPTH, 8, number of byte entries; power of two, 2..64.
- DIV_DEFAULT, 868, baud divisor after reset (clk cycles per bit; 100 MHz / 115200).
- DIV_W, 16, width of the divisor register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  bus write strobe for this slave, one cycle per write.
- addr  in  2  register select: 0 = TXDATA, 1 = DIV, 2 = CTRL, 3 = reserved.
- wdata  in  32  bus write data (Peripheral_in).
- rdata  out  32  combinational read-back.
- tx  out  1  serial output, registered, idle high.
- busy  out  1  frame in progress or FIFO non-empty; usable as an interrupt/poll line.

Behaviour:
- Reset values:
  - tx=1, busy=0, FIFO empty (count=0).
  - div=DIV_DEFAULT, overflow=0, FSM=IDLE.
  - rst mid-frame aborts immediately: tx=1 on the next cycle, FIFO contents discarded.
- Register writes (only when we=1):
  - addr 0: push wdata[7:0]. If the FIFO is full and no pop occurs the same cycle, drop the byte and set sticky overflow=1.
  - addr 1: div <= wdata[DIV_W-1:0]; a written value of 0 is stored as 1.
  - addr 2: wdata[0]=1 clears overflow; wdata[1]=1 flushes the FIFO. A flush does not abort the frame in flight.
  - addr 3: ignored.
- rdata (combinational on addr):
  - addr 1: {zero pad, div}.
  - Otherwise status = {zero[31:12], overflow[11], busy[10], full[9], empty[8], count[7:0]}. count is zero-extended, max FIFO_DEPTH.
- FIFO:
  - Synchronous, registered count, full = (count==FIFO_DEPTH).
  - Simultaneous push and pop is accepted at any fill level, including full; count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: if FIFO non-empty → pop into shift register, latch div into frame divisor, bit counter := div-1, tx<=0, go START.
  - START: hold tx=0 for div cycles; then go DATA with bit index 0, tx<=shift[0].
  - DATA: each bit lasts div cycles, LSB first. After bit 7, go STOP with tx<=1.
  - STOP: hold tx=1 for div cycles. At the end, if FIFO non-empty, pop and go START directly with no idle gap; else go IDLE.
- Timing:
  - A write to an empty FIFO in an idle block at edge k makes the FIFO non-empty after k. Pop occurs at edge k+1, and tx is low from edge k+2.
  - Frame length is exactly 10×div cycles. Back-to-back frames are contiguous.
- A divisor change takes effect at the next frame start only; the frame in flight keeps the latched divisor.
- busy = (FSM≠IDLE) | ~empty, registered-equivalent; it goes 0 in the cycle after the last STOP bit ends with the FIFO empty.

Decomposition:
- Shared package `uart_pkg`:
  - Register address constants (REG_TXDATA=0, REG_DIV=1, REG_CTRL=2).
  - Status bit positions.
  - FSM state encoding (2-bit enum).
- One sub-module `sync_byte_fifo` (parameter FIFO_DEPTH):
  - Ports: clk, rst, flush, push, din[7:0], pop, dout[7:0], count, full, empty.
  - Reusable for a later receiver.
- Top: register decode, baud counter, shifter FSM.

Test Plan:
- Reset then idle → tx=1, busy=0, rdata@addr0=0x00000100 (empty), rdata@addr1=868.
- div:=4, write 0xA5 at edge k → tx falls at k+2. Line then shows 0,1,0,1,0,0,1,0,1,1, each level 4 cycles (40 total). busy=0 one cycle after the stop bit ends.
- div:=2, write 0x55 and 0x0F on consecutive cycles → two contiguous 20-cycle frames with no idle gap between stop and start; count goes 1→0 as expected.
- div:=100, write 10 bytes quickly → first pops immediately, next 8 fill FIFO (full=1, count=8), 10th dropped with overflow=1. Write CTRL 0x1 → overflow=0, full still 1.
- Mid-frame: write div:=3 during a div=5 frame → current frame stays 50 cycles, next frame 30 cycles. Write div:=0 → rdata@addr1=1.
- Assert rst during DATA bit 3 → tx=1 next cycle, count=0, busy=0. Write CTRL 0x2 during a frame → FIFO emptied, current frame completes intact.
